// File: rtl/term_esc_parser_pkg.sv
// term_esc_parser_pkg: shared types, ASCII/control constants and SGR helpers for
// the terminal escape parser.
package term_esc_parser_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned COLOR_W = 12;
    localparam int unsigned PAL_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ESC  = 2'd1,
        ST_CSI  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam logic [BYTE_W-1:0] ASCII_ESC  = 8'h1B;
    localparam logic [BYTE_W-1:0] ASCII_LBRK = 8'h5B;
    localparam logic [BYTE_W-1:0] ASCII_QM   = 8'h3F;
    localparam logic [BYTE_W-1:0] ASCII_SEMI = 8'h3B;
    localparam logic [BYTE_W-1:0] ASCII_DEL  = 8'h7F;

    localparam logic [BYTE_W-1:0] FINAL_SGR = 8'h6D;  // 'm'
    localparam logic [BYTE_W-1:0] FINAL_ED  = 8'h4A;  // 'J'
    localparam logic [BYTE_W-1:0] FINAL_CUP = 8'h48;  // 'H'
    localparam logic [BYTE_W-1:0] FINAL_SET = 8'h68;  // 'h'
    localparam logic [BYTE_W-1:0] FINAL_RST = 8'h6C;  // 'l'

    localparam logic [BYTE_W-1:0] DEC_CURSOR_VIS = 8'd25;
    localparam logic [BYTE_W-1:0] DEC_CURSOR_BLK = 8'd12;

    localparam logic [BYTE_W-1:0] CTL_CLEAR = 8'h0C;
    localparam logic [BYTE_W-1:0] CTL_HOME  = 8'h1E;

    localparam logic [COLOR_W-1:0] FG_DEFAULT = 12'hFFF;
    localparam logic [COLOR_W-1:0] BG_DEFAULT = 12'h000;

    typedef struct packed {
        logic               cursor_visible;
        logic               cursor_block;
        logic [COLOR_W-1:0] fg;
        logic [COLOR_W-1:0] bg;
        logic               underline;
    } attr_t;

    // Palette index of an SGR colour code (30-37 or 40-47); meaningless otherwise.
    function automatic logic [PAL_W-1:0] sgr_pal_idx(input logic [BYTE_W-1:0] p);
        logic [BYTE_W-1:0] off;
        off = (p >= 8'd40) ? (p - 8'd40) : (p - 8'd30);
        return PAL_W'(off);
    endfunction

    // Decimal digit accumulate, saturating at 255.
    function automatic logic [BYTE_W-1:0] acc_digit(input logic [BYTE_W-1:0] p,
                                                    input logic [3:0] d);
        logic [11:0] t;
        t = 12'(p) * 12'd10 + 12'(d);
        return (t > 12'd255) ? 8'hFF : t[BYTE_W-1:0];
    endfunction

    // Apply one SGR parameter to the attribute set.
    function automatic attr_t sgr_apply(input attr_t a, input logic [BYTE_W-1:0] p,
                                        input logic [COLOR_W-1:0] pal);
        attr_t r;
        r = a;
        if (p == 8'd0) begin
            r.fg        = FG_DEFAULT;
            r.bg        = BG_DEFAULT;
            r.underline = 1'b0;
        end else if (p == 8'd4) begin
            r.underline = 1'b1;
        end else if (p == 8'd24) begin
            r.underline = 1'b0;
        end else if (p >= 8'd30 && p <= 8'd37) begin
            r.fg = pal;
        end else if (p >= 8'd40 && p <= 8'd47) begin
            r.bg = pal;
        end
        return r;
    endfunction

endpackage

// File: rtl/term_esc_parser_palette.sv
// term_palette: 3-bit ANSI colour index -> RGB444 (combinational).
//   idx    in  3   ANSI colour index (bit0 R, bit1 G, bit2 B)
//   rgb_c  out 12  RGB444 colour; index 7 maps to full white
module term_palette
    import term_esc_parser_pkg::*;
(
    input  logic [PAL_W-1:0]   idx,
    output logic [COLOR_W-1:0] rgb_c
);

    always_comb begin
        rgb_c = {idx[0] ? 4'hA : 4'h0, idx[1] ? 4'hA : 4'h0, idx[2] ? 4'hA : 4'h0};
        // White matches the reset foreground rather than the dim 0xAAA.
        if (idx == 3'd7) begin
            rgb_c = FG_DEFAULT;
        end
    end

endmodule

// File: rtl/term_esc_parser.sv
// term_esc_parser: byte-stream front end for the VGA character terminal. Decodes a
// small ANSI/VT100 subset (SGR colours/underline, DEC cursor modes, ED, CUP) and
// forwards printable/control bytes with a strobe followed by a write gap.
// Optional feature macro: TERM_ESC_TIMEOUT_EN (abandon idle ESC/CSI sequences).
//   clk, reset                   clock, async active-high reset
//   rx_data/rx_valid/rx_ready    byte input handshake
//   data/dataStrobe/dataType     emitted byte, one-cycle strobe, 1 = control code
//   cursorVisible/cursorBlock    cursor mode
//   fgColor/bgColor/underline    character attributes
module term_esc_parser
    import term_esc_parser_pkg::*;
#(
    parameter int unsigned STROBE_GAP  = 4
`ifdef TERM_ESC_TIMEOUT_EN
    , parameter int unsigned ESC_TIMEOUT = 1000000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BYTE_W-1:0]  rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [BYTE_W-1:0]  data,
    output logic               dataStrobe,
    output logic               dataType,
    output logic               cursorVisible,
    output logic               cursorBlock,
    output logic [COLOR_W-1:0] fgColor,
    output logic [COLOR_W-1:0] bgColor,
    output logic               underline
);

    localparam int unsigned GAP_W = (STROBE_GAP > 1) ? $clog2(STROBE_GAP) : 1;
    localparam attr_t ATTR_RESET = '{cursor_visible: 1'b1, cursor_block: 1'b1,
                                     fg: FG_DEFAULT, bg: BG_DEFAULT, underline: 1'b0};

    state_e             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [BYTE_W-1:0]  p0_q, p0_d, p1_q, p1_d;
    logic [1:0]         idx_q, idx_d;     // 2 = beyond second parameter, digits ignored
    logic               priv_q, priv_d;
    logic               first_q, first_d;
    logic               rx_ready_q, rx_ready_d;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic               strobe_q, strobe_d;
    logic               type_q, type_d;
    attr_t              attr_q, attr_d;

    logic               accept;
    logic               emit;
    logic [BYTE_W-1:0]  emit_byte;
    logic               emit_type;
    logic [PAL_W-1:0]   pal0_idx, pal1_idx;
    logic [COLOR_W-1:0] pal0_rgb, pal1_rgb;

    assign accept   = rx_valid && rx_ready_q;
    assign pal0_idx = sgr_pal_idx(p0_q);
    assign pal1_idx = sgr_pal_idx(p1_q);

    term_palette u_pal_p0 (.idx(pal0_idx), .rgb_c(pal0_rgb));
    term_palette u_pal_p1 (.idx(pal1_idx), .rgb_c(pal1_rgb));

`ifdef TERM_ESC_TIMEOUT_EN
    localparam int unsigned TMO_W = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT) : 1;
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Parser next-state, parameter accumulation and attribute execution.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        p0_d      = p0_q;
        p1_d      = p1_q;
        idx_d     = idx_q;
        priv_d    = priv_q;
        first_d   = first_q;
        data_d    = data_q;
        strobe_d  = 1'b0;
        type_d    = type_q;
        attr_d    = attr_q;
        emit      = 1'b0;
        emit_byte = rx_data;
        emit_type = 1'b0;
`ifdef TERM_ESC_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (rx_data == ASCII_ESC) begin
                        state_d = ST_ESC;
                    end else if (rx_data != ASCII_DEL) begin
                        emit      = 1'b1;
                        emit_type = (rx_data < 8'h20);
                    end
                end
            end
            ST_ESC: begin
                if (accept) begin
                    if (rx_data == ASCII_LBRK) begin
                        state_d = ST_CSI;
                        p0_d    = '0;
                        p1_d    = '0;
                        idx_d   = 2'd0;
                        priv_d  = 1'b0;
                        first_d = 1'b1;
                    end else if (rx_data != ASCII_ESC) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CSI: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
                        if (idx_q == 2'd0) begin
                            p0_d = acc_digit(p0_q, rx_data[3:0]);
                        end else if (idx_q == 2'd1) begin
                            p1_d = acc_digit(p1_q, rx_data[3:0]);
                        end
                    end else if (rx_data == ASCII_SEMI) begin
                        if (idx_q != 2'd2) begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else if (rx_data == ASCII_QM && first_q) begin
                        priv_d = 1'b1;
                    end else if (rx_data == ASCII_ESC) begin
                        state_d = ST_ESC;
                    end else if (rx_data >= 8'h40 && rx_data <= 8'h7E) begin
                        state_d = ST_IDLE;
                        if (!priv_q) begin
                            if (rx_data == FINAL_SGR) begin
                                attr_d = sgr_apply(attr_q, p0_q, pal0_rgb);
                                if (idx_q != 2'd0) begin
                                    attr_d = sgr_apply(attr_d, p1_q, pal1_rgb);
                                end
                            end else if (rx_data == FINAL_ED) begin
                                emit      = 1'b1;
                                emit_byte = CTL_CLEAR;
                                emit_type = 1'b1;
                            end else if (rx_data == FINAL_CUP) begin
                                emit      = 1'b1;
                                emit_byte = CTL_HOME;
                                emit_type = 1'b1;
                            end
                        end else if (rx_data == FINAL_SET || rx_data == FINAL_RST) begin
                            if (p0_q == DEC_CURSOR_VIS) begin
                                attr_d.cursor_visible = (rx_data == FINAL_SET);
                            end else if (p0_q == DEC_CURSOR_BLK) begin
                                attr_d.cursor_block = (rx_data == FINAL_SET);
                            end
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (emit) begin
            data_d   = emit_byte;
            type_d   = emit_type;
            strobe_d = 1'b1;
            state_d  = ST_GAP;
            gap_d    = GAP_W'(STROBE_GAP - 1);
        end

`ifdef TERM_ESC_TIMEOUT_EN
        // Reload on any byte that leaves us mid-sequence; count down while idle in one.
        if (accept) begin
            if (state_d == ST_ESC || state_d == ST_CSI) begin
                tmo_d = TMO_W'(ESC_TIMEOUT - 1);
            end
        end else if (state_q == ST_ESC || state_q == ST_CSI) begin
            if (tmo_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q - TMO_W'(1);
            end
        end
`endif

        rx_ready_d = (state_d != ST_GAP);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gap_q      <= '0;
            p0_q       <= '0;
            p1_q       <= '0;
            idx_q      <= 2'd0;
            priv_q     <= 1'b0;
            first_q    <= 1'b0;
            rx_ready_q <= 1'b1;
            data_q     <= '0;
            strobe_q   <= 1'b0;
            type_q     <= 1'b0;
            attr_q     <= ATTR_RESET;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            idx_q      <= idx_d;
            priv_q     <= priv_d;
            first_q    <= first_d;
            rx_ready_q <= rx_ready_d;
            data_q     <= data_d;
            strobe_q   <= strobe_d;
            type_q     <= type_d;
            attr_q     <= attr_d;
        end
    end

`ifdef TERM_ESC_TIMEOUT_EN
    // Escape inactivity counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign rx_ready      = rx_ready_q;
    assign data          = data_q;
    assign dataStrobe    = strobe_q;
    assign dataType      = type_q;
    assign cursorVisible = attr_q.cursor_visible;
    assign cursorBlock   = attr_q.cursor_block;
    assign fgColor       = attr_q.fg;
    assign bgColor       = attr_q.bg;
    assign underline     = attr_q.underline;

endmodule

// File: tb/tb_term_esc_parser.sv
// tb_term_esc_parser: directed self-checking bench for term_esc_parser.
// Build with TERM_ESC_TIMEOUT_EN defined to exercise the escape timeout (ESC_TIMEOUT=16).
module tb_term_esc_parser;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  data;
    logic        dataStrobe;
    logic        dataType;
    logic        cursorVisible;
    logic        cursorBlock;
    logic [11:0] fgColor;
    logic [11:0] bgColor;
    logic        underline;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

`ifdef TERM_ESC_TIMEOUT_EN
    term_esc_parser #(.STROBE_GAP(4), .ESC_TIMEOUT(16)) dut (
`else
    term_esc_parser #(.STROBE_GAP(4)) dut (
`endif
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .data(data), .dataStrobe(dataStrobe), .dataType(dataType),
        .cursorVisible(cursorVisible), .cursorBlock(cursorBlock),
        .fgColor(fgColor), .bgColor(bgColor), .underline(underline)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (dataStrobe) strobe_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Present one byte and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] b);
        int budget;
        budget = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 50) begin
            checks++; errors++;
            $display("FAIL send_wait byte=%h rx_ready=%b expected 1", b, rx_ready);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_csi(input string s);
        send(8'h1B);
        send(8'h5B);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
        checks++; if (dataStrobe !== 1'b0 || dataType !== 1'b0) begin errors++; $display("FAIL reset_strobe_type got=%b%b exp=00", dataStrobe, dataType); end
        checks++; if (cursorVisible !== 1'b1 || cursorBlock !== 1'b1) begin errors++; $display("FAIL reset_cursor got=%b%b exp=11", cursorVisible, cursorBlock); end
        checks++; if (fgColor !== 12'hFFF || bgColor !== 12'h000 || underline !== 1'b0) begin errors++; $display("FAIL reset_attr got fg=%h bg=%h ul=%b exp FFF 000 0", fgColor, bgColor, underline); end
    endtask

    task automatic test_emit_gap();
        int low;
        logic strobe2;
        low = 1; strobe2 = 1'b1;
        send(8'h41);
        checks++; if (dataStrobe !== 1'b1 || data !== 8'h41 || dataType !== 1'b0) begin errors++; $display("FAIL emit_A got s=%b d=%h t=%b exp 1 41 0", dataStrobe, data, dataType); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL emit_ready_low got=%b exp=0", rx_ready); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 0) strobe2 = dataStrobe;
            if (rx_ready) break;
            low++;
        end
        checks++; if (strobe2 !== 1'b0) begin errors++; $display("FAIL strobe_width got=%b exp=0 on 2nd cycle", strobe2); end
        checks++; if (low != 4) begin errors++; $display("FAIL gap_len got=%0d exp=4", low); end
        checks++; if (data !== 8'h41) begin errors++; $display("FAIL data_hold got=%h exp=41", data); end
    endtask

    task automatic test_char_classes();
        send(8'h1F);
        checks++; if (dataStrobe !== 1'b1 || data !== 8'h1F || dataType !== 1'b1) begin errors++; $display("FAIL ctl_1F got s=%b d=%h t=%b exp 1 1F 1", dataStrobe, data, dataType); end
        send(8'h20);
        checks++; if (dataStrobe !== 1'b1 || data !== 8'h20 || dataType !== 1'b0) begin errors++; $display("FAIL chr_20 got s=%b d=%h t=%b exp 1 20 0", dataStrobe, data, dataType); end
        send(8'h80);
        checks++; if (dataStrobe !== 1'b1 || data !== 8'h80 || dataType !== 1'b0) begin errors++; $display("FAIL chr_80 got s=%b d=%h t=%b exp 1 80 0", dataStrobe, data, dataType); end
        send(8'h7F);
        checks++; if (dataStrobe !== 1'b0 || rx_ready !== 1'b1 || data !== 8'h80) begin errors++; $display("FAIL del_drop got s=%b r=%b d=%h exp 0 1 80", dataStrobe, rx_ready, data); end
    endtask

    task automatic test_back_to_back();
        send(8'h42);
        send(8'h43);
        checks++; if (dataStrobe !== 1'b1 || data !== 8'h43) begin errors++; $display("FAIL b2b_second got s=%b d=%h exp 1 43", dataStrobe, data); end
        repeat (6) @(posedge clk); #1;
    endtask

    task automatic test_sgr();
        int s0;
        s0 = strobe_cnt;
        send_csi("31m");
        checks++; if (fgColor !== 12'hA00) begin errors++; $display("FAIL sgr31 fg got=%h exp=A00", fgColor); end
        send_csi("0m");
        checks++; if (fgColor !== 12'hFFF) begin errors++; $display("FAIL sgr0 fg got=%h exp=FFF", fgColor); end
        send_csi("4;42m");
        checks++; if (underline !== 1'b1 || bgColor !== 12'h0A0) begin errors++; $display("FAIL sgr4_42 got ul=%b bg=%h exp 1 0A0", underline, bgColor); end
        send_csi("999m");
        checks++; if (underline !== 1'b1 || bgColor !== 12'h0A0 || fgColor !== 12'hFFF) begin errors++; $display("FAIL sgr999 got ul=%b bg=%h fg=%h exp 1 0A0 FFF", underline, bgColor, fgColor); end
        send_csi("24;34;31m");
        checks++; if (underline !== 1'b0 || fgColor !== 12'h00A) begin errors++; $display("FAIL sgr_3params got ul=%b fg=%h exp 0 00A", underline, fgColor); end
        send_csi("47m");
        checks++; if (bgColor !== 12'hFFF) begin errors++; $display("FAIL sgr47 bg got=%h exp=FFF", bgColor); end
        @(posedge clk); #1;
        checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL sgr_no_strobe got=%0d exp=%0d", strobe_cnt, s0); end
    endtask

    task automatic test_private();
        send_csi("?25l");
        checks++; if (cursorVisible !== 1'b0 || cursorBlock !== 1'b1) begin errors++; $display("FAIL dec25l got v=%b b=%b exp 0 1", cursorVisible, cursorBlock); end
        send_csi("?12l");
        checks++; if (cursorBlock !== 1'b0) begin errors++; $display("FAIL dec12l got=%b exp=0", cursorBlock); end
        send_csi("?25h");
        checks++; if (cursorVisible !== 1'b1 || cursorBlock !== 1'b0) begin errors++; $display("FAIL dec25h got v=%b b=%b exp 1 0", cursorVisible, cursorBlock); end
        send_csi("25l");
        checks++; if (cursorVisible !== 1'b1) begin errors++; $display("FAIL nonpriv_l got=%b exp=1", cursorVisible); end
    endtask

    task automatic test_controls();
        send_csi("2J");
        checks++; if (dataStrobe !== 1'b1 || data !== 8'h0C || dataType !== 1'b1) begin errors++; $display("FAIL ed_clear got s=%b d=%h t=%b exp 1 0C 1", dataStrobe, data, dataType); end
        send_csi("H");
        checks++; if (dataStrobe !== 1'b1 || data !== 8'h1E || dataType !== 1'b1) begin errors++; $display("FAIL cup_home got s=%b d=%h t=%b exp 1 1E 1", dataStrobe, data, dataType); end
        repeat (6) @(posedge clk); #1;
    endtask

    task automatic test_restart_abort();
        int s0;
        send(8'h1B); send(8'h5B); send(8'h33);
        send_csi("32m");
        checks++; if (fgColor !== 12'h0A0) begin errors++; $display("FAIL esc_restart fg got=%h exp=0A0", fgColor); end
        s0 = strobe_cnt;
        send(8'h1B); send(8'h5B); send(8'h33); send(8'h20);
        send(8'h6D);
        checks++; if (dataStrobe !== 1'b1 || data !== 8'h6D || fgColor !== 12'h0A0) begin errors++; $display("FAIL csi_abort got s=%b d=%h fg=%h exp 1 6D 0A0", dataStrobe, data, fgColor); end
        checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL abort_drop strobes got=%0d exp=%0d", strobe_cnt, s0); end
        repeat (6) @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        send(8'h1B); send(8'h5B); send(8'h33);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        send(8'h31);
        checks++; if (dataStrobe !== 1'b1 || data !== 8'h31 || dataType !== 1'b0) begin errors++; $display("FAIL rst_mid_31 got s=%b d=%h t=%b exp 1 31 0", dataStrobe, data, dataType); end
        send(8'h6D);
        checks++; if (dataStrobe !== 1'b1 || data !== 8'h6D || dataType !== 1'b0) begin errors++; $display("FAIL rst_mid_6D got s=%b d=%h t=%b exp 1 6D 0", dataStrobe, data, dataType); end
        checks++; if (fgColor !== 12'hFFF) begin errors++; $display("FAIL rst_mid_fg got=%h exp=FFF", fgColor); end
        repeat (6) @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int s0;
        send(8'h1B); send(8'h5B);
        repeat (16) @(posedge clk);
        #1;
        s0 = strobe_cnt;
        send(8'h41);
`ifdef TERM_ESC_TIMEOUT_EN
        checks++; if (dataStrobe !== 1'b1 || data !== 8'h41 || dataType !== 1'b0) begin errors++; $display("FAIL timeout_emit got s=%b d=%h t=%b exp 1 41 0", dataStrobe, data, dataType); end
`else
        checks++; if (dataStrobe !== 1'b0 || strobe_cnt != s0) begin errors++; $display("FAIL no_timeout got s=%b cnt=%0d exp 0 %0d", dataStrobe, strobe_cnt, s0); end
`endif
        repeat (6) @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_emit_gap();
        test_char_classes();
        test_back_to_back();
        test_sgr();
        test_private();
        test_controls();
        test_restart_abort();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
